// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
// Combinational only; no latency or backpressure of its own.
package periph_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;

endpackage

// File: rtl/periph_bus_arbiter_pick.sv
// Winner select between two requesters: round-robin on ties, or m0 first in fixed mode.
// Purely combinational; shared by the idle-grant and release-handover paths.
module periph_arb_pick
    import periph_arb_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    input  logic i_fixed,
    output logic o_vld,
    output logic o_id
);

    always_comb begin
        o_vld = i_req0 | i_req1;
        o_id  = M0;
        if (i_req1 && !i_req0) begin
            o_id = M1;
        end else if (i_req0 && i_req1) begin
            o_id = i_fixed ? M0 : ~i_last_owner;
        end
    end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master peripheral bus arbiter: registered grant, combinational command mux and ack.
// Define PERIPH_ARB_FIXED_PRIO_EN for fixed m0 priority instead of round-robin.
module periph_bus_arbiter
    import periph_arb_pkg::*;
#(
    parameter int LOCK_MAX = 16,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic          m0_rd,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic          m1_rd,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_gnt,
    output logic          m1_gnt,
    output logic          m0_ack,
    output logic          m1_ack,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          bus_rd,
    output logic          bus_wr,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    output logic [1:0]    owner
);

    localparam int CW = $clog2(LOCK_MAX) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(LOCK_MAX);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef PERIPH_ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    state_t        r_state;
    state_t        w_next_state;
    logic          r_last_owner;
    logic          w_last_owner_nxt;
    logic [CW-1:0] r_lock_cnt;
    logic [CW-1:0] w_lock_cnt_nxt;

    logic          w_own_vld;
    logic          w_own_id;
    logic          w_cur_req;
    logic          w_cur_lock;
    logic          w_cur_rd;
    logic          w_cur_wr;
    logic [AW-1:0] w_cur_addr;
    logic [DW-1:0] w_cur_wdata;
    logic          w_oth_req;
    logic          w_ack;
    logic          w_bus_rd;
    logic          w_bus_wr;
    logic          w_force_ok;
    logic          w_force;
    logic          w_release;
    logic          w_pick_vld;
    logic          w_pick_id;

    assign w_own_vld   = (r_state != IDLE);
    assign w_own_id    = (r_state == OWN1);
    assign w_cur_req   = w_own_id ? m1_req   : m0_req;
    assign w_cur_lock  = w_own_id ? m1_lock  : m0_lock;
    assign w_cur_rd    = w_own_id ? m1_rd    : m0_rd;
    assign w_cur_wr    = w_own_id ? m1_wr    : m0_wr;
    assign w_cur_addr  = w_own_id ? m1_addr  : m0_addr;
    assign w_cur_wdata = w_own_id ? m1_wdata : m0_wdata;
    assign w_oth_req   = w_own_id ? m0_req   : m1_req;

    assign w_ack    = w_own_vld & w_cur_req & (w_cur_rd | w_cur_wr);
    assign w_bus_wr = w_own_vld & w_cur_req & w_cur_wr;
    assign w_bus_rd = w_own_vld & w_cur_req & w_cur_rd & ~w_cur_wr;

    // In fixed-priority mode a locked m0 is never forced out.
    assign w_force_ok = FIXED_PRIO ? w_own_id : 1'b1;
    assign w_force    = w_ack & w_cur_lock & (r_lock_cnt >= CNT_LAST) & w_oth_req & w_force_ok;
    assign w_release  = ~w_cur_req | (w_ack & ~w_cur_lock) | w_force;

    // last_owner equals the current owner while granted, so one picker serves both paths.
    periph_arb_pick u_pick (
        .i_req0       (m0_req),
        .i_req1       (m1_req),
        .i_last_owner (r_last_owner),
        .i_fixed      (FIXED_PRIO),
        .o_vld        (w_pick_vld),
        .o_id         (w_pick_id)
    );

    always_comb begin
        w_next_state     = r_state;
        w_last_owner_nxt = r_last_owner;
        w_lock_cnt_nxt   = r_lock_cnt;

        unique case (r_state)
            IDLE, OWN0, OWN1: begin
                if ((r_state == IDLE) || w_release) begin
                    if (w_pick_vld) begin
                        w_next_state = w_pick_id ? OWN1 : OWN0;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase

        if ((w_next_state != r_state) && (w_next_state != IDLE)) begin
            w_last_owner_nxt = (w_next_state == OWN1);
        end

        if (w_next_state != r_state) begin
            w_lock_cnt_nxt = '0;
        end else if (w_ack && w_cur_lock) begin
            if (r_lock_cnt < CNT_MAX) begin
                w_lock_cnt_nxt = r_lock_cnt + CNT_ONE;
            end
        end else if (w_ack) begin
            w_lock_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_owner <= M1;
            r_lock_cnt   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_last_owner <= w_last_owner_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
        end
    end

    assign m0_gnt    = (r_state == OWN0);
    assign m1_gnt    = (r_state == OWN1);
    assign owner     = {w_own_vld, w_own_id};
    assign m0_ack    = w_ack & m0_gnt;
    assign m1_ack    = w_ack & m1_gnt;
    assign m0_rdata  = (m0_gnt && w_bus_rd) ? bus_rdata : '0;
    assign m1_rdata  = (m1_gnt && w_bus_rd) ? bus_rdata : '0;
    assign bus_rd    = w_bus_rd;
    assign bus_wr    = w_bus_wr;
    assign bus_addr  = w_own_vld ? w_cur_addr  : '0;
    assign bus_wdata = w_own_vld ? w_cur_wdata : '0;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed bench for periph_bus_arbiter (default round-robin build).
module tb_periph_bus_arbiter;
    import periph_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_lock, m0_rd, m0_wr;
    logic [31:0] m0_addr, m0_wdata;
    logic        m1_req, m1_lock, m1_rd, m1_wr;
    logic [31:0] m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_rd, bus_wr;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [1:0]  owner;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    periph_bus_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_lock   (m0_lock),
        .m0_rd     (m0_rd),
        .m0_wr     (m0_wr),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m1_req    (m1_req),
        .m1_lock   (m1_lock),
        .m1_rd     (m1_rd),
        .m1_wr     (m1_wr),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m0_gnt    (m0_gnt),
        .m1_gnt    (m1_gnt),
        .m0_ack    (m0_ack),
        .m1_ack    (m1_ack),
        .m0_rdata  (m0_rdata),
        .m1_rdata  (m1_rdata),
        .bus_rd    (bus_rd),
        .bus_wr    (bus_wr),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .owner     (owner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_lock = 0; m0_rd = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_rd = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    initial begin
        reset = 1'b0;
        bus_rdata = '0;
        idle_inputs();
        #12;
        chk("rst m0_gnt", 32'(m0_gnt), 32'h0);
        chk("rst m1_gnt", 32'(m1_gnt), 32'h0);
        chk("rst owner", 32'(owner), 32'h0);
        chk("rst bus_rd", 32'(bus_rd), 32'h0);
        chk("rst bus_wr", 32'(bus_wr), 32'h0);
        chk("rst bus_addr", bus_addr, 32'h0);
        chk("rst m0_ack", 32'(m0_ack), 32'h0);
        chk("rst m1_rdata", m1_rdata, 32'h0);
        tick();
        reset = 1'b1;

        // Single read from IDLE
        m0_req = 1; m0_rd = 1; m0_addr = PERIPH_BASE + 32'h10; bus_rdata = 32'h5A;
        #1;
        chk("t1 pre gnt", 32'(m0_gnt), 32'h0);
        chk("t1 pre bus_rd", 32'(bus_rd), 32'h0);
        tick();
        chk("t1 gnt", 32'(m0_gnt), 32'h1);
        chk("t1 owner", 32'(owner), 32'h2);
        chk("t1 bus_rd", 32'(bus_rd), 32'h1);
        chk("t1 bus_addr", bus_addr, 32'h4000_0010);
        chk("t1 ack", 32'(m0_ack), 32'h1);
        chk("t1 rdata", m0_rdata, 32'h5A);
        chk("t1 m1_ack", 32'(m1_ack), 32'h0);
        tick();
        m0_req = 0; m0_rd = 0;
        #1;
        chk("t1 held gnt", 32'(m0_gnt), 32'h1);
        chk("t1 no ack", 32'(m0_ack), 32'h0);
        tick();
        chk("t1 idle gnt", 32'(m0_gnt), 32'h0);
        chk("t1 idle owner", 32'(owner), 32'h0);

        // Re-reset so last_owner is 1 again, then unlocked contention
        reset = 1'b0;
        tick();
        reset = 1'b1;
        m0_req = 1; m0_wr = 1; m0_addr = PERIPH_BASE + 32'h4; m0_wdata = 32'h11;
        m1_req = 1; m1_wr = 1; m1_addr = PERIPH_BASE + 32'h8; m1_wdata = 32'h22;
        #1;
        chk("t2 pre owner", 32'(owner), 32'h0);
        tick();
        chk("t2 c1 m0_gnt", 32'(m0_gnt), 32'h1);
        chk("t2 c1 m0_ack", 32'(m0_ack), 32'h1);
        chk("t2 c1 addr", bus_addr, 32'h4000_0004);
        chk("t2 c1 wdata", bus_wdata, 32'h11);
        tick();
        chk("t2 c2 m1_gnt", 32'(m1_gnt), 32'h1);
        chk("t2 c2 m0_gnt", 32'(m0_gnt), 32'h0);
        chk("t2 c2 m1_ack", 32'(m1_ack), 32'h1);
        chk("t2 c2 wdata", bus_wdata, 32'h22);
        tick();
        chk("t2 c3 m0_gnt", 32'(m0_gnt), 32'h1);
        chk("t2 c3 m0_ack", 32'(m0_ack), 32'h1);
        idle_inputs();
        tick();
        chk("t2 idle owner", 32'(owner), 32'h0);

        // m1 locked against a waiting m0; last_owner is 0 so m1 wins the tie
        m1_req = 1; m1_lock = 1; m1_wr = 1; m1_addr = PERIPH_BASE + 32'hC; m1_wdata = 32'h33;
        m0_req = 1; m0_rd = 1; m0_addr = PERIPH_BASE + 32'h14; bus_rdata = 32'h99;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t3 lock ack %0d", i), 32'({m0_gnt, m1_gnt, m1_ack}), 32'h3);
            tick();
        end
        chk("t3 m0_gnt", 32'(m0_gnt), 32'h1);
        chk("t3 m1_gnt", 32'(m1_gnt), 32'h0);
        chk("t3 m0_ack", 32'(m0_ack), 32'h1);
        chk("t3 m0_rdata", m0_rdata, 32'h99);
        tick();
        chk("t3 back to m1", 32'(owner), 32'h3);
        idle_inputs();
        tick();
        chk("t3 idle owner", 32'(owner), 32'h0);

        // rd and wr together: write wins
        m0_req = 1; m0_rd = 1; m0_wr = 1; m0_addr = PERIPH_BASE + 32'h18; m0_wdata = 32'h41;
        bus_rdata = 32'h77;
        tick();
        chk("t4 bus_wr", 32'(bus_wr), 32'h1);
        chk("t4 bus_rd", 32'(bus_rd), 32'h0);
        chk("t4 rdata", m0_rdata, 32'h0);
        chk("t4 ack", 32'(m0_ack), 32'h1);
        chk("t4 wdata", bus_wdata, 32'h41);
        tick();

        // m0 holds the bus without commands while m1 waits
        m0_rd = 0; m0_wr = 0;
        m1_req = 1; m1_wr = 1; m1_addr = PERIPH_BASE + 32'h1C; m1_wdata = 32'h55;
        #1;
        chk("t6 no ack", 32'(m0_ack), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("t6 hold gnt %0d", i), 32'({m0_gnt, m1_gnt}), 32'h2);
            chk($sformatf("t6 hold bus_wr %0d", i), 32'(bus_wr), 32'h0);
        end
        m0_req = 0;
        tick();
        chk("t6 m1_gnt", 32'(m1_gnt), 32'h1);
        chk("t6 m1_ack", 32'(m1_ack), 32'h1);
        chk("t6 bus_wr", 32'(bus_wr), 32'h1);
        chk("t6 bus_addr", bus_addr, 32'h4000_001C);

        // Asynchronous reset in the middle of m1's write
        #2;
        reset = 1'b0;
        #1;
        chk("t5 m1_gnt", 32'(m1_gnt), 32'h0);
        chk("t5 owner", 32'(owner), 32'h0);
        chk("t5 bus_wr", 32'(bus_wr), 32'h0);
        chk("t5 m1_ack", 32'(m1_ack), 32'h0);
        tick();
        chk("t5 held bus_wr", 32'(bus_wr), 32'h0);
        reset = 1'b1;
        m0_req = 1; m0_rd = 1; m0_addr = PERIPH_BASE; bus_rdata = 32'h12;
        tick();
        chk("t5 tie m0_gnt", 32'(m0_gnt), 32'h1);
        chk("t5 tie m1_gnt", 32'(m1_gnt), 32'h0);
        chk("t5 rdata", m0_rdata, 32'h12);
        idle_inputs();
        tick();
        chk("t5 idle owner", 32'(owner), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
